// File: rtl/instruction_fetch_buffer.sv
// ---------------------------------------------------------------------------
// instruction_fetch_buffer
//
// Fetch-side line buffer for the multicycle MIPS. Sits between the program
// counter and InstructionMemory and keeps the most recently read 128-bit line
// (four 32-bit words). A fetch that falls inside the buffered line is answered
// on the next clock edge without touching memory. A fetch outside the line
// drives the line base address to InstructionMemory, waits MEM_LATENCY cycles,
// captures the whole line, and delivers the requested word from it.
//
// Parameters
//   MEM_LATENCY : cycles from mem_address stable to dataline valid (1..15)
//   ADDR_WIDTH  : PC / memory address width
//
// Ports
//   clock       in   system clock, rising-edge
//   reset       in   asynchronous, active-high reset
//   pc          in   fetch byte address (bits [1:0] ignored)
//   fetch_req   in   one-cycle fetch request, sampled only while busy=0
//   flush       in   drops the buffered line and aborts an outstanding miss
//   mem_address out  line base address to InstructionMemory
//   dataline    in   128-bit line from InstructionMemory, word k at [32k+31:32k]
//   instruction out  last delivered instruction (held between deliveries)
//   inst_valid  out  one-cycle pulse when instruction is updated
//   busy        out  high while a miss is outstanding
//   hit         out  one-cycle pulse with inst_valid for a buffer hit
// ---------------------------------------------------------------------------
module instruction_fetch_buffer #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  fetch_req,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [127:0]          dataline,
  output logic [31:0]           instruction,
  output logic                  inst_valid,
  output logic                  busy,
  output logic                  hit
);

  localparam int unsigned TAG_WIDTH = ADDR_WIDTH - 4;

  // Counter preload: the counter reaches zero MEM_LATENCY-1 edges after the
  // request edge, and the line is captured on the edge after that.
  localparam logic [3:0] LATENCY_PRELOAD = 4'(MEM_LATENCY - 1);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t                 state;
  logic [3:0]             counter;
  logic [ADDR_WIDTH-1:2]  req_addr;    // word address of the pending miss
  logic [TAG_WIDTH-1:0]   tag;
  logic [127:0]           line_buf;
  logic                   line_valid;

  logic [TAG_WIDTH-1:0]   pc_tag;
  logic                   lookup_hit;

  // The byte offset within a word never affects the fetch.
  logic                   unused_pc_bits;
  assign unused_pc_bits = ^pc[1:0];

  assign pc_tag     = pc[ADDR_WIDTH-1:4];
  assign lookup_hit = line_valid && (tag == pc_tag);

  // Select 32-bit word idx from a 128-bit line.
  function automatic logic [31:0] word_sel(input logic [127:0] line,
                                           input logic [1:0]   idx);
    return line[{idx, 5'b00000} +: 32];
  endfunction

  // NOTE: every register here is state, so all assignments are non-blocking;
  // mixing in blocking assignments would make later statements see the new
  // values within the same edge and break the one-edge timing of each path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      counter     <= '0;
      req_addr    <= '0;
      tag         <= '0;
      // NOTE: the line storage is cleared on reset as well, so a freshly
      // reset buffer holds a defined all-zero line rather than whatever
      // the flops powered up with; line_valid alone guards its use.
      line_buf    <= '0;
      line_valid  <= 1'b0;
      mem_address <= '0;
      instruction <= '0;
      inst_valid  <= 1'b0;
      busy        <= 1'b0;
      hit         <= 1'b0;
    end else begin
      // Delivery strobes are single-cycle pulses.
      inst_valid <= 1'b0;
      hit        <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (flush) begin
            // Flush wins over a simultaneous fetch; the request is dropped.
            line_valid <= 1'b0;
          end else if (fetch_req) begin
            if (lookup_hit) begin
              instruction <= word_sel(line_buf, pc[3:2]);
              inst_valid  <= 1'b1;
              hit         <= 1'b1;
            end else begin
              req_addr    <= pc[ADDR_WIDTH-1:2];
              mem_address <= {pc_tag, 4'b0000};
              counter     <= LATENCY_PRELOAD;
              busy        <= 1'b1;
              state       <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (flush) begin
            // Abort the miss; mem_address keeps its last value.
            state      <= ST_IDLE;
            busy       <= 1'b0;
            line_valid <= 1'b0;
            counter    <= '0;
          end else if (counter == 4'd0) begin
            line_buf    <= dataline;
            tag         <= req_addr[ADDR_WIDTH-1:4];
            line_valid  <= 1'b1;
            instruction <= word_sel(dataline, req_addr[3:2]);
            inst_valid  <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            counter <= counter - 4'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_buffer
//
// Self-checking bench for instruction_fetch_buffer. A behavioural model tracks
// the single buffered line and any pending miss as a delivery deadline in
// cycles; a compare process checks every DUT output against it on each
// falling edge. Directed scenarios pin the model with literal values, then a
// randomized phase exercises hits, misses and flushes.
//
// The memory model returns {4'hA, byte_address[27:0]} for each word, which
// equals 32'hA000_0000|address for low addresses. dataline carries a junk
// pattern until mem_address has been stable long enough, so a line captured
// too early shows up as wrong data.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_buffer;

  localparam int unsigned LAT = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  pc = '0;
  logic         fetch_req = 1'b0;
  logic         flush = 1'b0;
  logic [31:0]  mem_address;
  logic [127:0] dataline;
  logic [31:0]  instruction;
  logic         inst_valid;
  logic         busy;
  logic         hit;

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch_buffer #(
    .MEM_LATENCY(LAT),
    .ADDR_WIDTH (32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pc         (pc),
    .fetch_req  (fetch_req),
    .flush      (flush),
    .mem_address(mem_address),
    .dataline   (dataline),
    .instruction(instruction),
    .inst_valid (inst_valid),
    .busy       (busy),
    .hit        (hit)
  );

  initial forever #5 clock = ~clock;

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {4'hA, a[27:2], 2'b00};
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] base);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_word(base + 32'(4*k));
    return l;
  endfunction

  logic [31:0]  last_addr = '0;
  int           stable_cnt = 0;
  logic [127:0] junk = 128'hDEAD_BEEF_0BAD_F00D_DEAD_BEEF_0BAD_F00D;

  initial forever begin
    @(negedge clock);
    if (mem_address !== last_addr) begin
      stable_cnt = 0;
      last_addr  = mem_address;
    end else if (stable_cnt < 1000) begin
      stable_cnt++;
    end
  end

  assign dataline = (stable_cnt >= int'(LAT) - 1) ? line_of(mem_address) : junk;

  // ---------------- behavioural model ----------------
  logic        m_line_valid = 1'b0;
  logic [27:0] m_tag = '0;
  logic        m_busy = 1'b0;
  logic [31:0] m_req_pc = '0;
  longint      m_done = 0;
  longint      cyc = 0;

  logic [31:0] e_mem_address = '0;
  logic [31:0] e_instruction = '0;
  logic        e_inst_valid = 1'b0;
  logic        e_busy = 1'b0;
  logic        e_hit = 1'b0;

  task automatic model_step();
    if (reset) begin
      m_line_valid  = 1'b0;
      m_tag         = '0;
      m_busy        = 1'b0;
      e_mem_address = '0;
      e_instruction = '0;
      e_inst_valid  = 1'b0;
      e_busy        = 1'b0;
      e_hit         = 1'b0;
      return;
    end
    cyc++;
    e_inst_valid = 1'b0;
    e_hit        = 1'b0;
    if (m_busy) begin
      if (flush) begin
        m_busy       = 1'b0;
        m_line_valid = 1'b0;
      end else if (cyc == m_done) begin
        e_instruction = mem_word(m_req_pc);
        e_inst_valid  = 1'b1;
        m_line_valid  = 1'b1;
        m_tag         = m_req_pc[31:4];
        m_busy        = 1'b0;
      end
    end else if (flush) begin
      m_line_valid = 1'b0;
    end else if (fetch_req) begin
      if (m_line_valid && m_tag == pc[31:4]) begin
        e_instruction = mem_word(pc);
        e_inst_valid  = 1'b1;
        e_hit         = 1'b1;
      end else begin
        m_busy        = 1'b1;
        m_req_pc      = pc;
        e_mem_address = {pc[31:4], 4'h0};
        m_done        = cyc + longint'(LAT);
      end
    end
    e_busy = m_busy;
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    model_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  initial forever begin
    @(negedge clock);
    check("cyc mem_address", mem_address, e_mem_address);
    check("cyc instruction", instruction, e_instruction);
    check("cyc inst_valid", 32'(inst_valid), 32'(e_inst_valid));
    check("cyc busy", 32'(busy), 32'(e_busy));
    check("cyc hit", 32'(hit), 32'(e_hit));
  end

  // Drive one fetch starting at a falling edge; return when inst_valid is seen.
  task automatic fetch(input logic [31:0] a, output logic [31:0] ins,
                       output logic h, output int lat,
                       output logic b1, output logic [31:0] m1);
    pc        = a;
    fetch_req = 1'b1;
    @(negedge clock);
    fetch_req = 1'b0;
    b1  = busy;
    m1  = mem_address;
    lat = 1;
    while (!inst_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    if (!inst_valid) check("fetch timeout", 32'(inst_valid), 32'd1);
    ins = instruction;
    h   = hit;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] ins, m1;
  logic        h, b1;
  int          lat, pulses;
  logic [31:0] bases [4] = '{32'h0000_0000, 32'h0000_0010, 32'h0000_0100, 32'hFFFF_FFF0};

  initial begin
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset mem_address", mem_address, 32'h0);
    check("reset instruction", instruction, 32'h0);
    check("reset inst_valid", 32'(inst_valid), 32'h0);
    check("reset busy", 32'(busy), 32'h0);

    // 1: first miss
    fetch(32'h0, ins, h, lat, b1, m1);
    check("s1 busy", 32'(b1), 32'd1);
    check("s1 mem_address", m1, 32'h0);
    check("s1 instruction", ins, 32'hA000_0000);
    check("s1 hit", 32'(h), 32'd0);
    check("s1 latency", 32'(lat), 32'(LAT + 1));

    // 2: hits in the same line, issued back-to-back with the previous pulse
    for (int i = 1; i < 4; i++) begin
      fetch(32'(4 * i), ins, h, lat, b1, m1);
      check("s2 instruction", ins, 32'hA000_0000 | 32'(4 * i));
      check("s2 hit", 32'(h), 32'd1);
      check("s2 latency", 32'(lat), 32'd1);
      check("s2 mem_address", mem_address, 32'h0);
    end

    // 3: next line misses, then the old line misses again
    fetch(32'h10, ins, h, lat, b1, m1);
    check("s3 mem_address", m1, 32'h10);
    check("s3 instruction", ins, 32'hA000_0010);
    check("s3 latency", 32'(lat), 32'(LAT + 1));
    fetch(32'h0, ins, h, lat, b1, m1);
    check("s3 refetch hit", 32'(h), 32'd0);
    check("s3 refetch latency", 32'(lat), 32'(LAT + 1));

    // 4: flush one cycle after a miss request
    pc = 32'h20; fetch_req = 1'b1;
    @(negedge clock);
    fetch_req = 1'b0; flush = 1'b1;
    check("s4 busy before flush", 32'(busy), 32'd1);
    @(negedge clock);
    flush = 1'b0;
    check("s4 busy after flush", 32'(busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (inst_valid) pulses++;
    end
    check("s4 no delivery", 32'(pulses), 32'd0);
    check("s4 mem_address kept", mem_address, 32'h20);
    fetch(32'h20, ins, h, lat, b1, m1);
    check("s4 refetch latency", 32'(lat), 32'(LAT + 1));
    check("s4 refetch instruction", ins, 32'hA000_0020);

    // 5: asynchronous reset in the middle of a miss
    pc = 32'h30; fetch_req = 1'b1;
    @(negedge clock);
    fetch_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("s5 async mem_address", mem_address, 32'h0);
    check("s5 async instruction", instruction, 32'h0);
    check("s5 async inst_valid", 32'(inst_valid), 32'h0);
    check("s5 async busy", 32'(busy), 32'h0);
    check("s5 async hit", 32'(hit), 32'h0);
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (inst_valid) pulses++;
    end
    check("s5 no delivery after reset", 32'(pulses), 32'd0);
    fetch(32'h4, ins, h, lat, b1, m1);
    check("s5 miss latency", 32'(lat), 32'(LAT + 1));
    check("s5 instruction", ins, 32'hA000_0004);

    // 6: top-of-memory line
    fetch(32'hFFFF_FFFC, ins, h, lat, b1, m1);
    check("s6 mem_address", m1, 32'hFFFF_FFF0);
    check("s6 instruction", ins, 32'hAFFF_FFFC);
    fetch(32'hFFFF_FFF4, ins, h, lat, b1, m1);
    check("s6 hit", 32'(h), 32'd1);
    check("s6 hit instruction", ins, 32'hAFFF_FFF4);

    // Flush in IDLE drops a simultaneous fetch and invalidates the line
    pc = 32'hFFFF_FFF4; fetch_req = 1'b1; flush = 1'b1;
    @(negedge clock);
    fetch_req = 1'b0; flush = 1'b0;
    check("idle flush inst_valid", 32'(inst_valid), 32'd0);
    check("idle flush busy", 32'(busy), 32'd0);
    fetch(32'hFFFF_FFF4, ins, h, lat, b1, m1);
    check("idle flush refetch latency", 32'(lat), 32'(LAT + 1));

    // Randomized phase, checked cycle by cycle against the model
    for (int i = 0; i < 600; i++) begin
      pc        = bases[$urandom_range(0, 3)] + 32'(4 * $urandom_range(0, 3))
                  + 32'($urandom_range(0, 3));
      fetch_req = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      @(negedge clock);
    end
    fetch_req = 1'b0;
    flush     = 1'b0;
    repeat (LAT + 4) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
